// File: rtl/pc_return_stack.sv
// ---------------------------------------------------------------------------
// pc_return_stack
//   16-bit program counter with an integrated hardware return-address stack.
//   OUT is the instruction fetch address; IN is the jump/call target.
//   One command per rising edge, priority RET > CALL > LOAD > INC > hold.
//
// Ports
//   CLK    system clock, all state updates on rising edge
//   RESET  asynchronous, active-high reset (OUT=0, LEVEL=0, flags clear)
//   IN     jump/call target address
//   LOAD   jump:   OUT <= IN
//   INC    advance: OUT <= OUT+1
//   CALL   push OUT+1, then OUT <= IN
//   RET    pop: OUT <= top of stack (acts as INC when empty)
//   OUT    current program counter (registered)
//   LEVEL  number of valid stack entries, 0..DEPTH
//   OVF    sticky: CALL attempted while full
//   UNF    sticky: RET attempted while empty
//
// Build option
//   RAS_CIRCULAR_EN  defined: a CALL while full overwrites the oldest entry
//                    (circular stack with a wrap pointer). Undefined: the
//                    push is dropped and the stack keeps its contents.
//                    OVF is set and the jump to IN happens in both builds.
// ---------------------------------------------------------------------------
module pc_return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int DW    = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic             LOAD,
  input  logic             INC,
  input  logic             CALL,
  input  logic             RET,
  output logic [WIDTH-1:0] OUT,
  output logic [DW-1:0]    LEVEL,
  output logic             OVF,
  output logic             UNF
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_inc;
  logic [DW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             push;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    rd_idx;
  logic             full;
  logic             empty;

  // Wraps modulo 2^WIDTH by construction.
  assign out_inc = out_q + WIDTH'(1);
  assign full    = (level_q == FULL);
  assign empty   = (level_q == '0);

`ifdef RAS_CIRCULAR_EN
  // Wrap pointer marks the next free slot; the oldest entry is the one it
  // lands on once the stack is full, so overwriting there drops the oldest.
  logic [PW-1:0] wp_q, wp_d;
  assign wr_idx = wp_q;
  assign rd_idx = wp_q - PW'(1);
`else
  // Linear stack: LEVEL is the push slot, LEVEL-1 the top. A push never
  // happens at LEVEL==DEPTH, so the truncated index is always in range.
  assign wr_idx = level_q[PW-1:0];
  assign rd_idx = level_q[PW-1:0] - PW'(1);
`endif

  always_comb begin
    out_d   = out_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
`ifdef RAS_CIRCULAR_EN
    wp_d    = wp_q;
`endif
    if (RET) begin
      if (!empty) begin
        out_d   = stack_q[rd_idx];
        level_d = level_q - DW'(1);
`ifdef RAS_CIRCULAR_EN
        wp_d    = wp_q - PW'(1);
`endif
      end else begin
        // Return with nothing stacked: fall through to the next address.
        out_d = out_inc;
        unf_d = 1'b1;
      end
    end else if (CALL) begin
      out_d = IN;
      if (!full) begin
        push    = 1'b1;
        level_d = level_q + DW'(1);
`ifdef RAS_CIRCULAR_EN
        wp_d    = wp_q + PW'(1);
`endif
      end else begin
        ovf_d = 1'b1;
`ifdef RAS_CIRCULAR_EN
        push  = 1'b1;
        wp_d  = wp_q + PW'(1);
`endif
      end
    end else if (LOAD) begin
      out_d = IN;
    end else if (INC) begin
      out_d = out_inc;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q   <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef RAS_CIRCULAR_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) wp_q <= '0;
    else       wp_q <= wp_d;
  end
`endif

  // Stack contents need no reset: entries above LEVEL are never read.
  always_ff @(posedge CLK) begin
    if (push) stack_q[wr_idx] <= out_inc;
  end

  assign OUT   = out_q;
  assign LEVEL = level_q;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule
